load_rs_param: RTL and testbench

Parametrised load reservation station for the Tomasulo core. It sits between the dispatch stage and the load functional unit. It buffers up to DEPTH load micro-ops, wakes their base operand by snooping NUM_CDB common data buses, and issues one address-ready load per cycle to the load unit with the effective address already computed. It supersedes the fixed 4-entry, single-CDB load station: it adds valid/ready handshakes on both sides, a pipeline flush, an occupancy count and selectable issue ordering.

---
 rtl/load_rs_pkg.sv | 24 ++
 rtl/load_rs_select.sv | 35 +++
 rtl/load_rs_param.sv | 215 +++++++++++++++++++++
 tb/tb_load_rs_param.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_rs_pkg.sv
// Shared definitions for the load reservation station: load subtypes, opcode,
// the invalid-tag encoding and the per-entry payload record.
package load_rs_pkg;

  localparam logic [2:0] LB_OP  = 3'b000;
  localparam logic [2:0] LH_OP  = 3'b001;
  localparam logic [2:0] LW_OP  = 3'b010;
  localparam logic [2:0] LBU_OP = 3'b100;
  localparam logic [2:0] LHU_OP = 3'b101;

  localparam logic [6:0] LOAD_OPCODE = 7'b0000011;

  // A tag equal to the ROB size never names a real ROB slot, so it marks "operand ready".
  function automatic int unsigned invalid_tag(input int unsigned rob_depth);
    return rob_depth;
  endfunction

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
  } entry_t;

endpackage

// File: rtl/load_rs_select.sv
// Issue picker: turns the ready vector into a one-hot grant, either lowest index
// or oldest-first when LOAD_RS_AGE_ORDER_EN supplies the age matrix.
module load_rs_select
  import load_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]       rdy,
`ifdef LOAD_RS_AGE_ORDER_EN
  input  logic [DEPTH*DEPTH-1:0] age,
`endif
  output logic [DEPTH-1:0]       grant,
  output logic                   valid
);

  always_comb begin
    grant = '0;
`ifdef LOAD_RS_AGE_ORDER_EN
    // Row i holds the entries older than i; grant i when none of those is ready.
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = rdy[i] && ((age[i*DEPTH +: DEPTH] & rdy) == '0);
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
`endif
  end

  assign valid = |rdy;

endmodule

// File: rtl/load_rs_param.sv
// Parametrised load reservation station: buffers loads, snoops the CDBs for the
// base operand and issues one address-computed load per cycle.
// Define LOAD_RS_AGE_ORDER_EN to issue oldest-ready first instead of lowest index.
module load_rs_param
  import load_rs_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_CDB   = 2,
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_rob,
  input  logic [2:0]                 disp_funct3,
  input  logic [31:0]                disp_base,
  input  logic [TAG_W-1:0]           disp_base_q,
  input  logic [31:0]                disp_offset,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_rob,
  input  logic [NUM_CDB*32-1:0]      cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [TAG_W-1:0]           iss_rob,
  output logic [2:0]                 iss_funct3,
  output logic [31:0]                iss_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] INV_TAG = TAG_W'(invalid_tag(ROB_DEPTH));

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] src_q [DEPTH];
  logic [TAG_W-1:0] src_d [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  logic [TAG_W-1:0] rob_d [DEPTH];
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];

  logic [DEPTH-1:0] rdy, grant, free_oh;
  logic             sel_valid, accept, issue;
  logic [TAG_W-1:0] disp_src;
  logic [31:0]      disp_val;
  logic [TAG_W-1:0] sel_rob;
  logic [2:0]       sel_funct3;
  logic [31:0]      sel_base, sel_offset;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = busy_q[i] && (src_q[i] == INV_TAG);
    end
  end

`ifdef LOAD_RS_AGE_ORDER_EN
  logic [DEPTH-1:0]       age_q [DEPTH];
  logic [DEPTH-1:0]       age_d [DEPTH];
  logic [DEPTH*DEPTH-1:0] age_flat;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_flat[i*DEPTH +: DEPTH] = age_q[i];
    end
  end

  load_rs_select #(.DEPTH(DEPTH)) u_select (
    .rdy   (rdy),
    .age   (age_flat),
    .grant (grant),
    .valid (sel_valid)
  );
`else
  load_rs_select #(.DEPTH(DEPTH)) u_select (
    .rdy   (rdy),
    .grant (grant),
    .valid (sel_valid)
  );
`endif

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;
  assign issue      = sel_valid && iss_ready && !flush;

  always_comb begin
    free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  // Same-cycle bypass for the incoming op; descending scan lets the lowest port win.
  always_comb begin
    disp_src = disp_base_q;
    disp_val = disp_base;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (disp_base_q != INV_TAG && cdb_valid[k] &&
          cdb_rob[k*TAG_W +: TAG_W] == disp_base_q) begin
        disp_src = INV_TAG;
        disp_val = cdb_data[k*32 +: 32];
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      src_d[i] = src_q[i];
      rob_d[i] = rob_q[i];
      ent_d[i] = ent_q[i];
      if (busy_q[i] && src_q[i] != INV_TAG) begin
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
          if (cdb_valid[k] && cdb_rob[k*TAG_W +: TAG_W] == src_q[i]) begin
            ent_d[i].base = cdb_data[k*32 +: 32];
            src_d[i]      = INV_TAG;
          end
        end
      end
      if (issue && grant[i]) begin
        busy_d[i] = 1'b0;
      end
      if (accept && free_oh[i]) begin
        busy_d[i]       = 1'b1;
        rob_d[i]        = disp_rob;
        src_d[i]        = disp_src;
        ent_d[i].funct3 = disp_funct3;
        ent_d[i].base   = disp_val;
        ent_d[i].offset = disp_offset;
      end
    end
    if (accept && !issue) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && issue) begin
      count_d = count_q - CNT_W'(1);
    end
    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

`ifdef LOAD_RS_AGE_ORDER_EN
  // New row marks everything already resident as older; freed entries drop out of every row.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (accept && free_oh[i]) begin
        age_d[i] = busy_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (!busy_d[j]) begin
          age_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    src_q <= src_d;
    rob_q <= rob_d;
    ent_q <= ent_d;
  end

  always_comb begin
    sel_rob    = '0;
    sel_funct3 = '0;
    sel_base   = '0;
    sel_offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_rob    = sel_rob | rob_q[i];
        sel_funct3 = sel_funct3 | ent_q[i].funct3;
        sel_base   = sel_base | ent_q[i].base;
        sel_offset = sel_offset | ent_q[i].offset;
      end
    end
  end

  assign iss_valid  = sel_valid;
  assign iss_rob    = sel_rob;
  assign iss_funct3 = sel_funct3;
  assign iss_addr   = sel_base + sel_offset;
  assign count      = count_q;

endmodule

// File: tb/tb_load_rs_param.sv
// Bench for load_rs_param: directed scenarios plus random traffic, checked every
// cycle against a sequence-numbered entry model.
module tb_load_rs_param;

  localparam int DEPTH     = 4;
  localparam int NUM_CDB   = 2;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 6;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     disp_valid;
  logic                     disp_ready;
  logic [TAG_W-1:0]         disp_rob;
  logic [2:0]               disp_funct3;
  logic [31:0]              disp_base;
  logic [TAG_W-1:0]         disp_base_q;
  logic [31:0]              disp_offset;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_rob;
  logic [NUM_CDB*32-1:0]    cdb_data;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [TAG_W-1:0]         iss_rob;
  logic [2:0]               iss_funct3;
  logic [31:0]              iss_addr;
  logic [2:0]               count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  load_rs_param #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob(disp_rob),
    .disp_funct3(disp_funct3), .disp_base(disp_base), .disp_base_q(disp_base_q),
    .disp_offset(disp_offset), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_data(cdb_data), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rob(iss_rob), .iss_funct3(iss_funct3), .iss_addr(iss_addr), .count(count)
  );

  typedef struct {
    bit          busy;
    int          rob;
    int          f3;
    logic [31:0] base;
    int          src;
    logic [31:0] off;
    int          seq;
  } ment_t;

  ment_t m [DEPTH];
  int    m_count;
  int    seq_ctr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && m[i].src == ROB_DEPTH) begin
`ifdef LOAD_RS_AGE_ORDER_EN
        if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic bit cdb_hit(input int tag, output logic [31:0] d);
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && int'(cdb_rob[k*TAG_W +: TAG_W]) == tag) begin
        d = cdb_data[k*32 +: 32];
        return 1'b1;
      end
    end
    d = '0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
    m_count = 0;
  endtask

  task automatic cmp_outputs();
    int s = pick();
    check("count", 32'(count), m_count);
    check("disp_ready", 32'(disp_ready), 32'(m_count < DEPTH));
    check("iss_valid", 32'(iss_valid), 32'(s >= 0));
    if (s >= 0) begin
      check("iss_addr", iss_addr, m[s].base + m[s].off);
      check("iss_rob", 32'(iss_rob), m[s].rob);
      check("iss_funct3", 32'(iss_funct3), m[s].f3);
    end
  endtask

  task automatic model_step();
    int          s = pick();
    int          fi = -1;
    bit          acc, iss;
    logic [31:0] d;
    acc = disp_valid && (m_count < DEPTH) && !flush;
    iss = (s >= 0) && iss_ready && !flush;
    if (flush) begin
      model_reset();
      return;
    end
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy && fi < 0) fi = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && m[i].src != ROB_DEPTH && cdb_hit(m[i].src, d)) begin
        m[i].base = d;
        m[i].src  = ROB_DEPTH;
      end
    end
    if (iss) m[s].busy = 1'b0;
    if (acc) begin
      m[fi].busy = 1'b1;
      m[fi].rob  = int'(disp_rob);
      m[fi].f3   = int'(disp_funct3);
      m[fi].base = disp_base;
      m[fi].src  = int'(disp_base_q);
      m[fi].off  = disp_offset;
      m[fi].seq  = seq_ctr;
      seq_ctr++;
      if (m[fi].src != ROB_DEPTH && cdb_hit(m[fi].src, d)) begin
        m[fi].base = d;
        m[fi].src  = ROB_DEPTH;
      end
    end
    m_count = m_count + int'(acc) - int'(iss);
  endtask

  task automatic step();
    cmp_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    disp_valid  = 1'b0;
    disp_rob    = '0;
    disp_funct3 = '0;
    disp_base   = '0;
    disp_base_q = '0;
    disp_offset = '0;
    cdb_valid   = '0;
    cdb_rob     = '0;
    cdb_data    = '0;
  endtask

  task automatic disp(input int rob, input int f3, input logic [31:0] base,
                      input int bq, input logic [31:0] off);
    disp_valid  = 1'b1;
    disp_rob    = TAG_W'(rob);
    disp_funct3 = 3'(f3);
    disp_base   = base;
    disp_base_q = TAG_W'(bq);
    disp_offset = off;
  endtask

  task automatic cdb(input int port, input int tag, input logic [31:0] data);
    cdb_valid[port]                 = 1'b1;
    cdb_rob[port*TAG_W +: TAG_W]    = TAG_W'(tag);
    cdb_data[port*32 +: 32]         = data;
  endtask

  logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    reset     = 1'b0;
    iss_ready = 1'b0;
    seq_ctr   = 0;
    idle();
    model_reset();
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_disp_ready", 32'(disp_ready), 1);
    check("rst_iss_valid", 32'(iss_valid), 0);
    check("rst_iss_addr", iss_addr, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;

    // Base ready at dispatch
    disp(3, 2, 32'h1000, ROB_DEPTH, -32'sd4);
    step();
    idle();
    check("t1_valid", 32'(iss_valid), 1);
    check("t1_addr", iss_addr, 32'h0FFC);
    check("t1_rob", 32'(iss_rob), 3);
    check("t1_f3", 32'(iss_funct3), 32'b010);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Fill, stall, wake all from port 1, drain
    for (int i = 0; i < DEPTH; i++) begin
      disp(10 + i, 2, 32'h100 * i, 5, 4 * i);
      step();
    end
    idle();
    check("fill_count", 32'(count), 4);
    check("fill_ready", 32'(disp_ready), 0);
    check("fill_wait", 32'(iss_valid), 0);
    cdb(1, 5, 32'h20);
    step();
    idle();
    check("wake_addr", iss_addr, 32'h20);
    iss_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    iss_ready = 1'b0;
    check("drain_count", 32'(count), 0);

    // Same-cycle bypass
    disp(20, 4, 32'h0, 7, 8);
    cdb(0, 7, 32'h80);
    step();
    idle();
    check("byp_valid", 32'(iss_valid), 1);
    check("byp_addr", iss_addr, 32'h88);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Backpressure with a second entry waking underneath
    disp(9, 1, 32'h200, ROB_DEPTH, 0);
    step();
    disp(11, 5, 32'h300, 4, 2);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) cdb(0, 4, 32'h400);
      check("bp_rob", 32'(iss_rob), 9);
      check("bp_addr", iss_addr, 32'h200);
      step();
      idle();
    end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check("bp_count", 32'(count), 1);
    check("bp_next_rob", 32'(iss_rob), 11);
    check("bp_next_addr", iss_addr, 32'h402);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Ordering: A waits in entry 0, B ready in entry 1, then A wakes
    disp(21, 0, 32'h0, 2, 1);
    step();
    disp(22, 0, 32'h50, ROB_DEPTH, 0);
    step();
    idle();
    cdb(1, 2, 32'h10);
    step();
    idle();
    check("ord_first", 32'(iss_rob), 21);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    disp(23, 0, 32'h60, ROB_DEPTH, 0);
    step();
    idle();
`ifdef LOAD_RS_AGE_ORDER_EN
    check("ord_second", 32'(iss_rob), 22);
`else
    check("ord_second", 32'(iss_rob), 23);
`endif
    iss_ready = 1'b1;
    step();
    step();
    iss_ready = 1'b0;

    // Flush with a concurrent dispatch at count 3
    for (int i = 0; i < 3; i++) begin
      disp(24 + i, 2, 32'h700, 6, i);
      step();
    end
    idle();
    disp(30, 2, 32'h900, ROB_DEPTH, 0);
    flush = 1'b1;
    step();
    idle();
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(iss_valid), 0);
    step();
    check("flush_dropped", 32'(iss_valid), 0);

    // Reset asserted mid-issue
    disp(31, 2, 32'h40, ROB_DEPTH, 0);
    step();
    idle();
    iss_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(iss_valid), 0);
    check("arst_ready", 32'(disp_ready), 1);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    iss_ready = 1'b0;

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        disp(int'($urandom_range(0, 15)), int'(f3s[$urandom_range(0, 4)]), $urandom,
             ($urandom_range(0, 1) != 0) ? ROB_DEPTH : int'($urandom_range(0, 7)), $urandom);
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid[k]               = ($urandom_range(0, 2) == 0);
        cdb_rob[k*TAG_W +: TAG_W]  = TAG_W'($urandom_range(0, 7));
        cdb_data[k*32 +: 32]       = $urandom;
      end
      iss_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    idle();
    iss_ready = 1'b0;
    cmp_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
